pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Resolves hazard sources into per-register hold and bubble controls:
  - ID branch/jump operand hazards
  - load-use hazards
  - instruction- and data-bus wait states
  - the multi-cycle divider
  - precise exceptions from MEM
- Sequences the divider's busy window and the drain of a stale in-flight fetch after an exception redirect.
- Register indices used below: R0=PC, R1=IF/ID, R2=ID/EX, R3=EX/MEM, R4=MEM/WB.

Parameters:
- DIV_CYCLES, 32, number of cycles the divider holds EX after the start cycle; legal range 2 to 64.
- CNT_W, $clog2(DIV_CYCLES), counter width; derived, not overridden.

Ports:
- clk_i  in  1  clock; one clock domain, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- j_b_stall_i  in  1  ID branch/jr/jalr operand depends on EX result
- flush_delay_slot_i  in  1  branch-likely not taken; squash delay slot
- id_rs_i  in  5  ID source register rs
- id_rt_i  in  5  ID source register rt
- ex_rmem_i  in  1  EX instruction is a load
- ex_waddr_i  in  5  EX destination register
- ex_div_i  in  1  EX instruction is DIV/DIVU
- ibus_stall_i  in  1  fetch not yet returned
- dbus_stall_i  in  1  MEM data access not yet complete
- exc_i  in  1  MEM-stage exception/eret accepted
- stall_o  out  5  bit k holds register Rk
- flush_o  out  5  bit k loads bubble into Rk; bit0 always 0
- pc_redirect_o  out  1  PC loads exception/eret target this cycle
- div_start_o  out  1  one-cycle divider start strobe
- div_cancel_o  out  1  abort in-progress divide
- div_done_o  out  1  divider result consumed by EX this cycle
- busy_o  out  1  state != RUN

Behaviour:
- State machine: RUN, DIV, DRAIN. Divider counter cnt has width CNT_W.
- Reset:
  - state=RUN, cnt=0.
  - While rst_i is high, all outputs are 0.
- All outputs are combinational from the current state and inputs. Next state is registered.

Hazard sources (highest priority first):
1. exc_i. Result: stall_o=0, flush_o=5'b11110, pc_redirect_o=1. All other sources are ignored.
2. dbus_stall_i. Result: hold R0..R3, bubble R4.
3. Divider hold. Result: hold R0..R2, bubble R3. Active when:
   - state is RUN and ex_div_i is asserted, or
   - state is DIV and cnt != 0.
4. Load-use or j_b_stall_i. Result: hold R0..R1, bubble R2. Load-use means ex_rmem_i is set, ex_waddr_i != 0, and ex_waddr_i matches id_rs_i or id_rt_i.
5. ibus_stall_i. Result: hold R0, bubble R1.

Combining hazard sources:
- The deepest held register index wins.
- stall_o is contiguous from bit0 up to that index.
- The register just above the deepest held one is flushed.

Delay-slot squash (flush_delay_slot_i):
- Sets flush_o[1] only when stall_o[1]=0 and exc_i=0.
- When R1 is held, the squash is deferred until ID proceeds; the input stays asserted while the branch sits in ID.

Divider sequencing:
- RUN to DIV when ex_div_i=1, exc_i=0 and dbus_stall_i=0:
  - div_start_o=1 that cycle
  - cnt loads DIV_CYCLES-1
- DIV:
  - cnt decrements each cycle with dbus_stall_i=0.
  - cnt==0 with dbus_stall_i=0: div_done_o=1, the divider hold releases, next state RUN.
  - cnt==0 with dbus_stall_i=1: stay in DIV and hold.
- Timing: EX is occupied for DIV_CYCLES+1 cycles in total; the start cycle is counted.

Exceptions:
- exc_i while in DIV: div_cancel_o=1 and cnt is cleared.
- exc_i with ibus_stall_i=1: next state DRAIN.
- exc_i otherwise: next state RUN.
- DRAIN:
  - flush_o[1]=1 every cycle, including the cycle ibus_stall_i drops.
  - The fetch stall rule still applies.
  - Exit to RUN when ibus_stall_i=0.
  - exc_i in DRAIN restarts the drain.
- Reset mid-DIV or mid-DRAIN: return to RUN next edge; no cancel strobe is generated.

Decomposition:
- Shared package pipe_pkg:
  - ctrl_state_e (RUN/DIV/DRAIN)
  - register-index constants R_PC..R_MEMWB
  - DIV_CYCLES default
- Sub-module div_sequencer: counter plus start/cancel/done strobes.
- The priority merge stays in the top level.

Test Plan:
- Load-use: ex_rmem_i=1, ex_waddr_i=5, id_rs_i=5 -> stall_o=00011, flush_o=00100 for one cycle. Same with ex_waddr_i=0 -> no stall.
- Divide: ex_div_i=1, DIV_CYCLES=4 -> div_start_o at cycle0, stall_o=00111 for cycles 0-3, div_done_o at cycle4 with stall_o=00000.
- Divide plus dbus: dbus_stall_i=1 during the cycle when cnt==0 -> stall_o=01111, flush_o=10000, div_done_o delayed until dbus_stall_i falls.
- Exception mid-divide: exc_i at cycle 2 of DIV -> flush_o=11110, pc_redirect_o=1, div_cancel_o=1, state RUN, busy_o=0.
- Exception with pending fetch: exc_i with ibus_stall_i=1 for 3 more cycles -> flush_o[1]=1 for 4 cycles after the exception, then RUN.
- Delay-slot squash: flush_delay_slot_i with j_b_stall_i=1 -> no flush_o[1]. Next cycle with j_b_stall_i=0 -> flush_o=00010.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Register indices name the pipeline registers that stall_o/flush_o bits steer.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN,
        DIV,
        DRAIN
    } ctrl_state_e;

    localparam int R_PC    = 0;
    localparam int R_IFID  = 1;
    localparam int R_IDEX  = 2;
    localparam int R_EXMEM = 3;
    localparam int R_MEMWB = 4;
    localparam int N_REGS  = 5;

    localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/pipeline_ctrl_div_sequencer.sv
// Divider busy-window counter and its start/cancel/done strobes.
// The counter holds the number of cycles EX still waits after the start cycle.
module div_sequencer
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  ctrl_state_e state_i,
    input  logic        ex_div_i,
    input  logic        exc_i,
    input  logic        dbus_stall_i,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        div_done_o,
    output logic        div_hold_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             in_run;
    logic             in_div;
    logic             cnt_zero;

    assign in_run   = (state_i == RUN);
    assign in_div   = (state_i == DIV);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        div_start_o  = 1'b0;
        div_cancel_o = 1'b0;
        div_done_o   = 1'b0;
        div_hold_o   = 1'b0;
        if (!rst_i) begin
            div_start_o  = in_run & ex_div_i & ~exc_i & ~dbus_stall_i;
            div_cancel_o = in_div & exc_i;
            div_done_o   = in_div & cnt_zero & ~dbus_stall_i & ~exc_i;
            div_hold_o   = (in_run & ex_div_i) | (in_div & ~cnt_zero);
        end
    end

    // A memory stall freezes the count so EX never loses divide cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (in_div && exc_i) begin
            cnt_d = '0;
        end else if (div_start_o) begin
            cnt_d = CNT_LOAD;
        end else if (in_div && !dbus_stall_i && !cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler: merges hazard sources into per-register
// hold/bubble controls and sequences divide and post-exception fetch drain.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       j_b_stall_i,
    input  logic       flush_delay_slot_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_rmem_i,
    input  logic [4:0] ex_waddr_i,
    input  logic       ex_div_i,
    input  logic       ibus_stall_i,
    input  logic       dbus_stall_i,
    input  logic       exc_i,
    output logic [4:0] stall_o,
    output logic [4:0] flush_o,
    output logic       pc_redirect_o,
    output logic       div_start_o,
    output logic       div_cancel_o,
    output logic       div_done_o,
    output logic       busy_o
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic div_hold;
    logic load_use;

    div_sequencer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .state_i      (state_q),
        .ex_div_i     (ex_div_i),
        .exc_i        (exc_i),
        .dbus_stall_i (dbus_stall_i),
        .div_start_o  (div_start_o),
        .div_cancel_o (div_cancel_o),
        .div_done_o   (div_done_o),
        .div_hold_o   (div_hold)
    );

    assign load_use = ex_rmem_i && (ex_waddr_i != 5'd0)
                   && ((ex_waddr_i == id_rs_i) || (ex_waddr_i == id_rt_i));

    // Deepest held register wins; the one above it takes the bubble.
    always_comb begin
        stall_o       = '0;
        flush_o       = '0;
        pc_redirect_o = 1'b0;
        busy_o        = 1'b0;
        if (!rst_i) begin
            if (exc_i) begin
                flush_o = 5'b11110;
            end else if (dbus_stall_i) begin
                stall_o = 5'b01111;
                flush_o = 5'b10000;
            end else if (div_hold) begin
                stall_o = 5'b00111;
                flush_o = 5'b01000;
            end else if (load_use || j_b_stall_i) begin
                stall_o = 5'b00011;
                flush_o = 5'b00100;
            end else if (ibus_stall_i) begin
                stall_o = 5'b00001;
                flush_o = 5'b00010;
            end
            if (!exc_i && flush_delay_slot_i && !stall_o[R_IFID]) begin
                flush_o[R_IFID] = 1'b1;
            end
            if (state_q == DRAIN) begin
                flush_o[R_IFID] = 1'b1;
            end
            pc_redirect_o = exc_i;
            busy_o        = (state_q != RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        if (exc_i) begin
            state_d = ibus_stall_i ? DRAIN : RUN;
        end else begin
            unique case (state_q)
                RUN:     if (div_start_o) state_d = DIV;
                DIV:     if (div_done_o) state_d = RUN;
                DRAIN:   if (!ibus_stall_i) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
